// File: rtl/vram_text_arbiter.sv
// vram_text_arbiter
// Shares the single-port, synchronous-read text VRAM between a row burst
// into an internal line buffer and a host on a req/ack handshake. The burst
// runs during hsync of each line that starts a character row. The display
// path reads cells from the line buffer, so it never touches the RAM port.
// Build option: define VRAM_TEXT_ARBITER_READBACK_EN to add host reads
// (i_host_we, o_host_rdata and the HOST_RD state).
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | RAM port free; a fetch (new or pending) beats the host
// FETCH   | one row read per cycle, column counter advancing
// DRAIN   | last fetched word lands in the line buffer
// HOST    | host address on the RAM port; we=1 for a write
// HOST_RD | host read data captured and acked (readback builds only)

module vram_text_arbiter #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int CELL_W = 8,
  parameter int CELL_H = 16,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_hs,
  input  logic              i_blanking,
  input  logic [9:0]        i_x,
  input  logic [8:0]        i_y,
  output logic [DATA_W-1:0] o_cell,
  output logic              o_cell_valid,
  input  logic              i_host_req,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_wdata,
`ifdef VRAM_TEXT_ARBITER_READBACK_EN
  input  logic              i_host_we,
  output logic [DATA_W-1:0] o_host_rdata,
`endif
  output logic              o_host_ack,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_we,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  localparam int               COL_W    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int               CW_SH    = $clog2(CELL_W);
  localparam int               CH_SH    = $clog2(CELL_H);
  localparam logic [8:0]       VBLANK_Y = 9'(ROWS * CELL_H - 1);
  localparam logic [9:0]       COLS_X   = 10'(COLS);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_HOST
`ifdef VRAM_TEXT_ARBITER_READBACK_EN
    , S_HOST_RD
`endif
  } state_t;

  state_t              state, state_nxt;
  logic                hs_q;
  logic                trigger;
  logic                fetch_pending;
  logic [COL_W-1:0]    col;
  logic                col_last;
  logic [ADDR_W-1:0]   row_base;
  logic [ADDR_W-1:0]   row_base_nxt;
  logic                lb_wr;
  logic [COL_W-1:0]    lb_wr_col;
  logic                host_wr;
  logic                host_busy;
  logic                in_fetch;
  logic [9:0]          x_col;
  logic [COL_W-1:0]    rd_idx;
  logic [DATA_W-1:0]   linebuf [COLS];

`ifdef VRAM_TEXT_ARBITER_READBACK_EN
  assign host_wr   = i_host_we;
  assign host_busy = (state == S_HOST) || (state == S_HOST_RD);
`else
  assign host_wr   = 1'b1;
  assign host_busy = (state == S_HOST);
`endif

  // hsync falling edge on a row-start line; the clamped vblank line is excluded
  assign trigger      = hs_q && !i_hs && (i_y[CH_SH-1:0] == '0) && (i_y != VBLANK_Y);
  assign row_base_nxt = ADDR_W'(i_y >> CH_SH) * ADDR_W'(COLS);
  assign in_fetch     = (state == S_FETCH) || (state == S_DRAIN);
  assign col_last     = (col == LAST_COL);
  assign x_col        = i_x >> CW_SH;
  assign rd_idx       = COL_W'(x_col);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state and RAM port drive; only FETCH and HOST put an address out
  always_comb begin
    state_nxt   = state;
    o_ram_addr  = '0;
    o_ram_we    = 1'b0;
    o_ram_wdata = '0;
    case (state)
      S_IDLE: begin
        if (trigger || fetch_pending) state_nxt = S_FETCH;
        else if (i_host_req)          state_nxt = S_HOST;
      end
      S_FETCH: begin
        o_ram_addr = row_base + ADDR_W'(col);
        if (col_last) state_nxt = S_DRAIN;
      end
      S_DRAIN: state_nxt = S_IDLE;
      S_HOST: begin
        o_ram_addr = i_host_addr;
        o_ram_we   = host_wr;
        if (host_wr) o_ram_wdata = i_host_wdata;
`ifdef VRAM_TEXT_ARBITER_READBACK_EN
        state_nxt = host_wr ? S_IDLE : S_HOST_RD;
`else
        state_nxt = S_IDLE;
`endif
      end
`ifdef VRAM_TEXT_ARBITER_READBACK_EN
      S_HOST_RD: state_nxt = S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Fetch bookkeeping, pending flag and host acknowledge
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hs_q          <= 1'b0;
      fetch_pending <= 1'b0;
      col           <= '0;
      row_base      <= '0;
      lb_wr         <= 1'b0;
      lb_wr_col     <= '0;
      o_host_ack    <= 1'b0;
`ifdef VRAM_TEXT_ARBITER_READBACK_EN
      o_host_rdata  <= '0;
`endif
    end else begin
      hs_q <= i_hs;
      // A burst in flight keeps its row; otherwise latch it (also for a pending fetch)
      if (trigger && !in_fetch) row_base <= row_base_nxt;
      if (trigger && host_busy)                         fetch_pending <= 1'b1;
      else if (state == S_IDLE && state_nxt == S_FETCH) fetch_pending <= 1'b0;
      if (state == S_FETCH && !col_last) col <= col + 1'b1;
      else                               col <= '0;
      lb_wr      <= (state == S_FETCH);
      lb_wr_col  <= col;
`ifdef VRAM_TEXT_ARBITER_READBACK_EN
      o_host_ack <= (state == S_HOST && host_wr) || (state == S_HOST_RD);
      if (state == S_HOST_RD) o_host_rdata <= i_ram_rdata;
`else
      o_host_ack <= (state == S_HOST);
`endif
    end
  end

  // Line buffer fill: read data for column c arrives the cycle after its address
  always_ff @(posedge i_clk) begin
    if (lb_wr) linebuf[lb_wr_col] <= i_ram_rdata;
  end

  // Display path: one-cycle registered lookup of the cell under the pixel
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_cell       <= '0;
      o_cell_valid <= 1'b0;
    end else begin
      o_cell_valid <= ~i_blanking;
      o_cell       <= (x_col < COLS_X) ? linebuf[rd_idx] : '0;
    end
  end

endmodule

// File: doc/vram_text_arbiter.md
# vram_text_arbiter

Shares the single-port, synchronous-read text-mode video RAM between the display path and a host writer. It is driven by the 640x480 timing generator's sync, blanking and x/y outputs. During the horizontal sync of every line that starts a character row, it bursts that row's cells into an internal line buffer. The display reads pixels from the line buffer, and all other RAM cycles go to the host through a req/ack handshake.

## Interface
Parameters:
- COLS, 80, character cells per row
- ROWS, 30, character rows per screen
- CELL_W, 8, pixel width of a cell (power of two)
- CELL_H, 16, pixel height of a cell (power of two)
- ADDR_W, 12, VRAM word address width
- DATA_W, 16, VRAM word width (one cell)

Ports:
- i_clk  in  1  pixel clock, sole clock
- i_rst  in  1  asynchronous reset, active-high
- i_hs  in  1  horizontal sync from timing generator (active low)
- i_blanking  in  1  high outside active area
- i_x  in  10  active pixel x
- i_y  in  9  active pixel y (clamped to 479 in vblank)
- o_cell  out  DATA_W  cell word for the current pixel
- o_cell_valid  out  1  o_cell belongs to an active pixel
- i_host_req  in  1  host access request; hold until ack
- i_host_addr  in  ADDR_W  host cell address
- i_host_wdata  in  DATA_W  host write data
- o_host_ack  out  1  one-cycle pulse: access complete
- o_ram_addr  out  ADDR_W  VRAM address
- o_ram_we  out  1  VRAM write enable
- o_ram_wdata  out  DATA_W  VRAM write data
- i_ram_rdata  in  DATA_W  VRAM read data, valid one cycle after address

## Operation
- Fetch trigger: registered i_hs is 1, current i_hs is 0, and i_y mod CELL_H == 0. Vblank lines (y=479) never trigger.
- Fetch row = i_y / CELL_H. The fetch reads addresses row*COLS + c, for c = 0..COLS-1, with we=0.
- The read issued for column c is written to linebuf[c] on the next cycle.
- States:
  - IDLE: trigger or pending fetch goes to FETCH; else i_host_req goes to HOST.
  - FETCH: issues one read per cycle. After c = COLS-1 it goes to DRAIN.
  - DRAIN: captures the last word, then goes to IDLE.
  - HOST: drives the host address and data with we=1 for one cycle and pulses o_host_ack. Goes to IDLE (or HOST_RD under the macro).
- Priority: a fetch always beats the host. A trigger arriving in HOST or HOST_RD sets fetch_pending. The host access finishes, then FETCH starts from IDLE and fetch_pending clears.
- Host is never granted in the cycle a trigger is seen. Back-to-back host requests get one access per two cycles (HOST then IDLE).
- Display path: o_cell <= linebuf[i_x / CELL_W], and o_cell_valid <= ~i_blanking, both registered.
- Row arithmetic uses an ADDR_W-bit product. Addresses at or beyond COLS*ROWS are the host's responsibility and are passed through unchecked.
- Reset (async, any state, including mid-fetch): state IDLE, fetch_pending=0, column counter 0, all outputs 0. Line buffer contents are undefined until the first fetch completes.

## Timing
- Fetch occupies COLS+2 cycles from the trigger: 1 cycle entering FETCH, COLS issue cycles, 1 DRAIN cycle.
- With defaults a fetch starts at h_count 17 and finishes by h_count 99, before active video at 160. A worst-case pending host access adds at most 2 cycles.
- Host write latency is 2 cycles from request in IDLE to ack.
- Display latency is 1 cycle from i_x/i_blanking to o_cell/o_cell_valid.
- o_ram_we is high only in HOST, with a write selected.

## Configuration
- VRAM_TEXT_ARBITER_READBACK_EN defined:
  - Adds input i_host_we (1) and output o_host_rdata (DATA_W).
  - A host read (i_host_we=0) goes HOST (we=0), then HOST_RD.
  - o_host_rdata is captured from i_ram_rdata in HOST_RD and o_host_ack pulses there, giving 3-cycle read latency.
  - o_host_rdata resets to 0 and holds its value between reads.
- Not defined: those ports and HOST_RD do not exist, and every host access is a write.

## Test plan
- Reset mid-fetch: assert i_rst during FETCH at c=40 -> o_ram_addr=0, we=0, ack=0 immediately; after release, no reads until the next trigger.
- Row fetch: y=32, hs falls -> reads at addresses 160..239 on consecutive cycles; then x=8..15 in active video -> o_cell = word stored at 161, one cycle after x.
- No vblank fetch: y=479 and y=15 hs edges -> no RAM reads issued.
- Host write during idle: req, addr=0x123, data=0xBEEF -> RAM we=1 at 0x123 with 0xBEEF, ack one cycle later; a repeat req is acked every 2 cycles.
- Collision: host req asserted the same cycle as a trigger -> all 80 reads complete first, then the write, and the ack arrives COLS+4 cycles after the request.
- READBACK_EN: write 0x5A5A to 0x010, then read 0x010 -> o_host_rdata=0x5A5A with ack 3 cycles after the read request.
